alu_cmd_sequencer: RTL and testbench

Buffered command front-end for the four-bit ALU: accepts {opcode, a, b, chain} commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It issues one command per cycle into an internal `TOP_fourbit_ALU` instance and registers the result, carry, overflow and zero flags. Results are presented downstream over a second valid/ready handshake. An optional chain bit replaces operand a with the previous result, which allows multi-step accumulation without software round-trips.

---
 rtl/alu_cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Buffered command front-end for the four-bit ALU: a DEPTH-entry command FIFO
// feeding a registered ALU stage, with valid/ready handshakes on both sides.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_opcode,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic                       in_chain,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_result,
  output logic                       out_cout,
  output logic                       out_v,
  output logic                       out_zero,
  output logic [2:0]                 out_opcode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic       chain;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_acc;
  logic          r_out_valid;
  logic [3:0]    r_out_result;
  logic          r_out_cout;
  logic          r_out_v;
  logic          r_out_zero;
  logic [2:0]    r_out_opcode;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_issue;
  cmd_t          w_head;
  cmd_t          w_in_cmd;
  logic [3:0]    w_alu_a;
  logic [3:0]    w_alu_result;
  logic          w_alu_cout;
  logic          w_alu_v;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_issue  = !w_empty && (!r_out_valid || out_ready);

  assign w_in_cmd = '{opcode: in_opcode, a: in_a, b: in_b, chain: in_chain};
  assign w_head   = r_mem[r_rd_ptr];
  assign w_alu_a  = w_head.chain ? r_acc : w_head.a;

  TOP_fourbit_ALU u_alu (
    .i_opcode (w_head.opcode),
    .i_a      (w_alu_a),
    .i_b      (w_head.b),
    .o_result (w_alu_result),
    .o_cout   (w_alu_cout),
    .o_v      (w_alu_v)
  );

  // NOTE: FIFO storage has no reset; stale entries are unreachable because the
  // pointers and count are reset, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_cmd;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cout   <= 1'b0;
      r_out_v      <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_opcode <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_acc        <= w_alu_result;
        r_out_valid  <= 1'b1;
        r_out_result <= w_alu_result;
        r_out_cout   <= w_alu_cout;
        r_out_v      <= w_alu_v;
        r_out_zero   <= (w_alu_result == 4'd0);
        r_out_opcode <= w_head.opcode;
      end else if (r_out_valid && out_ready) begin
        r_out_valid  <= 1'b0;
      end

      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;
  assign out_v      = r_out_v;
  assign out_zero   = r_out_zero;
  assign out_opcode = r_out_opcode;
  assign count      = r_count;

endmodule

// Combinational four-bit ALU: add/sub with carry and signed overflow, bitwise
// ops and low-nibble multiply; reserved opcodes yield zero.
module TOP_fourbit_ALU (
  input  logic [2:0] i_opcode,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_result,
  output logic       o_cout,
  output logic       o_v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic       w_is_sub;
  logic [3:0] w_b_eff;
  logic [4:0] w_sum;

  // Subtraction is a + ~b + 1, so cout is the raw carry (1 means no borrow).
  assign w_is_sub = (i_opcode == OP_SUB);
  assign w_b_eff  = w_is_sub ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {4'd0, w_is_sub};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_result = 4'd0;
    o_cout   = 1'b0;
    o_v      = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB: begin
        o_result = w_sum[3:0];
        o_cout   = w_sum[4];
        o_v      = (i_a[3] == w_b_eff[3]) && (w_sum[3] != i_a[3]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_MUL:  o_result = i_a * i_b;
      default: o_result = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: directed commands push hand-computed results into a queue,
// and a monitor compares every result the sequencer hands downstream.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_chain;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_cout;
  logic       out_v;
  logic       out_zero;
  logic [2:0] out_opcode;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  // Expected response packed as {result, cout, v, zero, opcode}.
  logic [9:0] exp_q[$];

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_chain   (in_chain),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_v      (out_v),
    .out_zero   (out_zero),
    .out_opcode (out_opcode),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {22'd0, out_result, out_cout, out_v, out_zero, out_opcode}, 32'h3ff);
      end else begin
        check("result", {22'd0, out_result, out_cout, out_v, out_zero, out_opcode},
              {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic chain, input logic [3:0] e_res, input logic e_c,
                          input logic e_v, input logic e_z);
    bit accepted = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_chain  = chain;
    exp_q.push_back({e_res, e_c, e_v, e_z, op});
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    if (!accepted) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count == 0) done = 1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    in_chain  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_state", {out_valid, out_result, out_cout, out_v, out_zero, out_opcode, count}, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    out_ready = 1'b1;

    // Add with signed overflow, plus one-cycle FIFO latency.
    push_cmd(3'b000, 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    check("latency_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_valid", out_valid, 1);
    drain();

    // Subtraction: equal operands, then a borrow.
    push_cmd(3'b001, 4'd5, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    push_cmd(3'b001, 4'd2, 4'd5, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0);
    // Multiply low nibble, reserved opcode, bitwise ops.
    push_cmd(3'b101, 4'd7, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b110, 4'd9, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    push_cmd(3'b011, 4'd5, 4'd10, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b100, 4'd12, 4'd10, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back chaining: 2+3=5, 5+4=9 (overflow), 9&12=8.
    push_cmd(3'b000, 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd15, 4'd4, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    push_cmd(3'b010, 4'd15, 4'd12, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: one in the result register, four fill the FIFO.
    out_ready = 1'b0;
    push_cmd(3'b000, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd3, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd4, 4'd2, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd5, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    fork
      push_cmd(3'b000, 4'd6, 4'd2, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("stall_hold", {out_valid, out_result, count}, {1'b1, 4'd3, 3'd4});
        check("stall_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("full_pop_no_refill", in_ready, 0);
      end
    join
    drain();

    // Reset mid-run with a pending result and three queued entries.
    out_ready = 1'b0;
    push_cmd(3'b000, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd1, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    push_cmd(3'b000, 4'd1, 4'd4, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    check("pre_rst", {out_valid, count}, {1'b1, 3'd3});
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst", {out_valid, count, in_ready}, {1'b0, 3'd0, 1'b1});
    out_ready = 1'b1;
    push_cmd(3'b000, 4'd9, 4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
